divider_sign_seq: RTL and testbench

//   Request sequencer placed directly upstream of the iterative unsigned

---
 rtl/divider_sign_seq_pkg.sv | 26 ++
 rtl/divider_sign_seq_fixup.sv | 30 +++
 rtl/divider_sign_seq.sv | 143 ++++++++++++++
 tb/tb_divider_sign_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/divider_sign_seq_pkg.sv
// divSeqPkg: state encoding and sign helpers shared by the divider sequencer.
// Rev 1.0
`default_nettype none

package divSeqPkg;

  // Helpers operate on a wide container; callers extend and truncate to their width.
  localparam int MAX_W = 64;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  function automatic logic [MAX_W-1:0] negCond(input logic [MAX_W-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  // x must arrive sign-extended when signed_en is set.
  function automatic logic [MAX_W-1:0] absVal(input logic [MAX_W-1:0] x, input logic signed_en);
    return negCond(x, signed_en & x[MAX_W-1]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/divider_sign_seq_fixup.sv
// div_sign_fixup: restores signs on the unsigned divider quotient/remainder.
// Rev 1.0
`default_nettype none

module div_sign_fixup
  import divSeqPkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] raw_q,
  input  logic [WIDTH-1:0] raw_r,
  input  logic             dividend_neg,
  input  logic             divisor_neg,
  input  logic             is_signed,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  logic q_neg;
  logic r_neg;

  assign q_neg = is_signed & (dividend_neg ^ divisor_neg);
  assign r_neg = is_signed & dividend_neg;

  assign q = WIDTH'(negCond({{(MAX_W-WIDTH){1'b0}}, raw_q}, q_neg));
  assign r = WIDTH'(negCond({{(MAX_W-WIDTH){1'b0}}, raw_r}, r_neg));

endmodule

`default_nettype wire

// File: rtl/divider_sign_seq.sv
// divider_sign_seq: request sequencer that wraps an iterative unsigned divider.
// Rev 1.0
`default_nettype none

module divider_sign_seq
  import divSeqPkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cg,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_signed,
  input  logic [TAG_W-1:0] i_req_tag,
  input  logic [WIDTH-1:0] i_req_dividend,
  input  logic [WIDTH-1:0] i_req_divisor,
  output logic             o_div_begin,
  output logic [WIDTH-1:0] o_div_dividend,
  output logic [WIDTH-1:0] o_div_divisor,
  input  logic             i_div_done,
  input  logic [WIDTH-1:0] i_div_quotient,
  input  logic [WIDTH-1:0] i_div_remainder,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic [WIDTH-1:0] o_rsp_quotient,
  output logic [WIDTH-1:0] o_rsp_remainder
);

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [1:0]       state;
  logic             is_signed;
  logic             dividend_neg;
  logic             divisor_neg;

  logic             req_dvd_neg;
  logic             req_dsr_neg;
  logic [WIDTH-1:0] req_dvd_mag;
  logic [WIDTH-1:0] req_dsr_mag;
  logic             div_by_zero;
  logic             overflow;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;

  assign req_dvd_neg = i_req_signed & i_req_dividend[WIDTH-1];
  assign req_dsr_neg = i_req_signed & i_req_divisor[WIDTH-1];
  assign req_dvd_mag = WIDTH'(absVal({{(MAX_W-WIDTH){req_dvd_neg}}, i_req_dividend}, i_req_signed));
  assign req_dsr_mag = WIDTH'(absVal({{(MAX_W-WIDTH){req_dsr_neg}}, i_req_divisor}, i_req_signed));

  assign div_by_zero = (i_req_divisor == '0);
  assign overflow    = i_req_signed & (i_req_dividend == MIN_VAL) & (i_req_divisor == ALL_ONES);

  div_sign_fixup #(
    .WIDTH(WIDTH)
  ) u_fixup (
    .raw_q       (i_div_quotient),
    .raw_r       (i_div_remainder),
    .dividend_neg(dividend_neg),
    .divisor_neg (divisor_neg),
    .is_signed   (is_signed),
    .q           (fix_q),
    .r           (fix_r)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      is_signed       <= 1'b0;
      dividend_neg    <= 1'b0;
      divisor_neg     <= 1'b0;
      o_req_ready     <= 1'b1;
      o_div_begin     <= 1'b0;
      o_div_dividend  <= '0;
      o_div_divisor   <= '0;
      o_rsp_valid     <= 1'b0;
      o_rsp_tag       <= '0;
      o_rsp_quotient  <= '0;
      o_rsp_remainder <= '0;
    end else if (i_cg) begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            o_req_ready    <= 1'b0;
            o_rsp_tag      <= i_req_tag;
            is_signed      <= i_req_signed;
            dividend_neg   <= req_dvd_neg;
            divisor_neg    <= req_dsr_neg;
            o_div_dividend <= req_dvd_mag;
            o_div_divisor  <= req_dsr_mag;
            // Corner cases are answered locally without waking the divider.
            if (div_by_zero) begin
              o_rsp_quotient  <= ALL_ONES;
              o_rsp_remainder <= i_req_dividend;
              o_rsp_valid     <= 1'b1;
              state           <= RESP;
            end else if (overflow) begin
              o_rsp_quotient  <= MIN_VAL;
              o_rsp_remainder <= '0;
              o_rsp_valid     <= 1'b1;
              state           <= RESP;
            end else begin
              o_div_begin <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          o_div_begin <= 1'b0;
          state       <= WAIT;
        end
        WAIT: begin
          if (i_div_done) begin
            o_rsp_quotient  <= fix_q;
            o_rsp_remainder <= fix_r;
            o_rsp_valid     <= 1'b1;
            state           <= RESP;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_req_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
          o_div_begin <= 1'b0;
          o_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_divider_sign_seq.sv
// tb_divider_sign_seq: directed and random requests against an arithmetic reference model.
// Rev 1.0
`default_nettype none

module tb_divider_sign_seq;

  localparam int WIDTH = 8;
  localparam int TAG_W = 2;
  localparam int D     = 9;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cg = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_signed = 1'b0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [WIDTH-1:0] req_dividend = '0;
  logic [WIDTH-1:0] req_divisor = '0;
  logic             req_ready;
  logic             div_begin;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_done;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [TAG_W-1:0] rsp_tag;
  logic [WIDTH-1:0] rsp_q;
  logic [WIDTH-1:0] rsp_r;

  int   checks = 0;
  int   errors = 0;
  int   begin_count = 0;
  int   cnt = 0;
  logic inject = 1'b0;

  always #5 clk = ~clk;

  divider_sign_seq #(
    .WIDTH(WIDTH),
    .TAG_W(TAG_W)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_cg           (cg),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_signed   (req_signed),
    .i_req_tag      (req_tag),
    .i_req_dividend (req_dividend),
    .i_req_divisor  (req_divisor),
    .o_div_begin    (div_begin),
    .o_div_dividend (div_dividend),
    .o_div_divisor  (div_divisor),
    .i_div_done     (div_done),
    .i_div_quotient (div_q),
    .i_div_remainder(div_r),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_tag      (rsp_tag),
    .o_rsp_quotient (rsp_q),
    .o_rsp_remainder(rsp_r)
  );

  // Unsigned divider stand-in: done pulses D cycles after the begin cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 0;
      div_q <= '0;
      div_r <= '0;
    end else if (div_begin) begin
      cnt   <= D;
      div_q <= (div_divisor == 0) ? '1 : div_dividend / div_divisor;
      div_r <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end
  end

  always @(posedge clk) if (div_begin) begin_count <= begin_count + 1;

  assign div_done = (cnt == 1) || inject;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic void model(input bit sg, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r, output bit corner);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    corner = 1'b0;
    if (b == 0) begin
      q = 8'hFF;
      r = a;
      corner = 1'b1;
    end else if (sg && sa == -128 && sb == -1) begin
      q = 8'h80;
      r = 8'h00;
      corner = 1'b1;
    end else if (sg) begin
      q = 8'(sa / sb);
      r = 8'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called just after a negedge; returns just after the negedge following the handshake.
  task automatic run_req(input bit sg, input logic [1:0] tag, input logic [7:0] a,
                         input logic [7:0] b, input int hold, input bit cg_hold);
    logic [7:0] eq;
    logic [7:0] er;
    bit         corner;
    int         n;
    int         b0;
    model(sg, a, b, eq, er, corner);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_signed = sg;
    req_tag = tag;
    req_dividend = a;
    req_divisor = b;
    b0 = begin_count;
    @(negedge clk);
    req_valid = 1'b0;
    req_dividend = 8'($urandom);
    req_divisor = 8'($urandom);
    req_tag = 2'($urandom);
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), corner ? 32'd1 : 32'(D + 2));
    check("tag", 32'(rsp_tag), 32'(tag));
    check("quotient", 32'(rsp_q), 32'(eq));
    check("remainder", 32'(rsp_r), 32'(er));
    check("begin_pulses", 32'(begin_count - b0), corner ? 32'd0 : 32'd1);
    for (int i = 0; i < hold; i++) begin
      rsp_ready = cg_hold;
      cg = !cg_hold;
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_quotient", 32'(rsp_q), 32'(eq));
      check("hold_remainder", 32'(rsp_r), 32'(er));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    cg = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("valid_after_hs", 32'(rsp_valid), 32'd0);
    check("ready_after_hs", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    int         sel;
    int         hold;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_begin", 32'(div_begin), 32'd0);
    check("rst_quotient", 32'(rsp_q), 32'd0);
    check("rst_remainder", 32'(rsp_r), 32'd0);
    check("rst_tag", 32'(rsp_tag), 32'd0);
    check("rst_div_dividend", 32'(div_dividend), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_req(1'b0, 2'd1, 8'd200, 8'd7, 0, 1'b0);
    run_req(1'b1, 2'd2, 8'hF9, 8'h02, 0, 1'b0);
    run_req(1'b1, 2'd3, 8'h07, 8'hFE, 0, 1'b0);
    run_req(1'b1, 2'd0, 8'h85, 8'h00, 0, 1'b0);
    run_req(1'b1, 2'd1, 8'h80, 8'hFF, 0, 1'b0);
    run_req(1'b0, 2'd2, 8'h80, 8'hFF, 10, 1'b0);
    run_req(1'b1, 2'd3, 8'h81, 8'h05, 3, 1'b1);

    // Reset while the divider is busy, then a stray done pulse in IDLE.
    req_valid = 1'b1;
    req_signed = 1'b0;
    req_tag = 2'd3;
    req_dividend = 8'd100;
    req_divisor = 8'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_div_dividend", 32'(div_dividend), 32'd0);
    check("midrst_tag", 32'(rsp_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_done_valid", 32'(rsp_valid), 32'd0);
    check("stray_done_ready", 32'(req_ready), 32'd1);

    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 9));
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (sel == 0) rb = 8'h00;
      if (sel == 1) begin
        ra = 8'h80;
        rb = 8'hFF;
      end
      hold = int'($urandom_range(0, 2));
      run_req(1'($urandom), 2'($urandom), ra, rb, hold, (hold > 0) && ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
